// File: rtl/led_fade_pwm_if.sv
// Pattern-in / PWM-out bundle between the chaser logic and the LED fade stage.
interface led_fade_pwm_if;
    logic       enable_i;
    logic [7:0] pattern_i;
    logic [7:0] led_o;
    logic       pwm_sync_o;

    modport master (output enable_i, output pattern_i, input led_o, input pwm_sync_o);
    modport slave  (input enable_i, input pattern_i, output led_o, output pwm_sync_o);
endinterface

// File: rtl/led_fade_pwm.sv
// Per-LED PWM with trailing afterglow: lit pattern bits load full brightness, dropped bits decay.
// Optional GAMMA_EN macro applies a square-law brightness curve at each shadow load.
module led_fade_pwm #(
    parameter int unsigned PWM_BITS       = 4,
    parameter int unsigned DECAY_PRESCALE = 65536,
    parameter int unsigned DECAY_STEP     = 1
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    led_fade_pwm_if.slave  bus
);
    localparam int unsigned NLED = 8;
    localparam int unsigned MAX  = (1 << PWM_BITS) - 1;
    localparam int unsigned P    = MAX;
    localparam int unsigned DW   = (DECAY_PRESCALE > 1) ? $clog2(DECAY_PRESCALE) : 1;
`ifdef GAMMA_EN
    localparam int unsigned GW   = 2 * PWM_BITS;
`endif

    logic [PWM_BITS-1:0]            pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0]                  decay_cnt_q, decay_cnt_d;
    logic [NLED-1:0][PWM_BITS-1:0]  level_q, level_d;
    logic [NLED-1:0][PWM_BITS-1:0]  shadow_q, shadow_d;
    logic [NLED-1:0][PWM_BITS-1:0]  shadow_src;
    logic [NLED-1:0]                led_q, led_d;
    logic                           sync_q, sync_d;
    logic                           decay_tick;
    logic                           period_end;

    assign decay_tick = (decay_cnt_q == DW'(DECAY_PRESCALE - 1));
    assign period_end = (pwm_cnt_q == PWM_BITS'(P - 1));

`ifdef GAMMA_EN
    function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] lvl);
        logic [GW-1:0] sq;
        sq = GW'(lvl) * GW'(lvl) + GW'(MAX);
        return sq[GW-1:PWM_BITS];
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < NLED; k++) shadow_src[k] = gamma(level_q[k]);
    end
`else
    assign shadow_src = level_q;
`endif

    // Counters, per-LED level/shadow and the registered output compare.
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q;
        decay_cnt_d = decay_cnt_q;
        level_d     = level_q;
        shadow_d    = shadow_q;
        led_d       = '0;
        sync_d      = 1'b0;
        if (!bus.enable_i) begin
            pwm_cnt_d   = '0;
            decay_cnt_d = '0;
            level_d     = '0;
            shadow_d    = '0;
        end else begin
            pwm_cnt_d   = period_end ? '0 : pwm_cnt_q + PWM_BITS'(1);
            decay_cnt_d = decay_tick ? '0 : decay_cnt_q + DW'(1);
            sync_d      = (pwm_cnt_q == '0);
            for (int unsigned k = 0; k < NLED; k++) begin
                // Load wins over a coincident decay tick.
                if (bus.pattern_i[k]) begin
                    level_d[k] = PWM_BITS'(MAX);
                end else if (decay_tick) begin
                    level_d[k] = (level_q[k] > PWM_BITS'(DECAY_STEP))
                               ? level_q[k] - PWM_BITS'(DECAY_STEP) : '0;
                end
                if (period_end) shadow_d[k] = shadow_src[k];
                led_d[k] = (pwm_cnt_q < shadow_q[k]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pwm_cnt_q   <= '0;
            decay_cnt_q <= '0;
            level_q     <= '0;
            shadow_q    <= '0;
            led_q       <= '0;
            sync_q      <= 1'b0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            decay_cnt_q <= decay_cnt_d;
            level_q     <= level_d;
            shadow_q    <= shadow_d;
            led_q       <= led_d;
            sync_q      <= sync_d;
        end
    end

    assign bus.led_o      = led_q;
    assign bus.pwm_sync_o = sync_q;
endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with PWM_BITS=4, DECAY_PRESCALE=8, DECAY_STEP=1 (15-cycle period).
module tb_led_fade_pwm;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   hi [8];
    int   sh0;
    logic extra_sync;
    logic sync_next;
    logic found;

    led_fade_pwm_if bus_if ();

    led_fade_pwm #(.PWM_BITS(4), .DECAY_PRESCALE(8), .DECAY_STEP(1)) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed %0d, expected %0d", tag, (obs), (exp)); \
        end \
    end

    task automatic wait_sync();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_if.pwm_sync_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        `CHK("sync_timeout", found, 1'b1)
    endtask

    // Called on a sync sample; counts high cycles of one period and checks the next sync.
    task automatic meas();
        for (int b = 0; b < 8; b++) hi[b] = 0;
        extra_sync = 1'b0;
        sh0 = int'(dut.shadow_q[0]);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            for (int b = 0; b < 8; b++) hi[b] += int'(bus_if.led_o[b]);
            if (i > 0 && bus_if.pwm_sync_o === 1'b1) extra_sync = 1'b1;
        end
        @(negedge clk);
        sync_next = bus_if.pwm_sync_o;
    endtask

    initial begin
        int prev, lvl, ndec, bad_step, bad_int, last, zero_at, prev_hi, others;
        checks = 0;
        errors = 0;

        // 1. reset and blanking
        rstn = 1'b0;
        bus_if.enable_i  = 1'b1;
        bus_if.pattern_i = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            `CHK("rst_led", bus_if.led_o, 8'h00)
            `CHK("rst_sync", bus_if.pwm_sync_o, 1'b0)
        end
        bus_if.enable_i = 1'b0;
        rstn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            `CHK("dis_led", bus_if.led_o, 8'h00)
            `CHK("dis_sync", bus_if.pwm_sync_o, 1'b0)
        end
        `CHK("dis_level", dut.level_q, 32'd0)

        // 2. steady full brightness
        bus_if.pattern_i = 8'h01;
        bus_if.enable_i  = 1'b1;
        @(negedge clk);
        `CHK("en_first_sync", bus_if.pwm_sync_o, 1'b1)
        meas();
        `CHK("first_period_dark", hi[0], 0)
        `CHK("sync_period1", sync_next, 1'b1)
        repeat (2) begin
            meas();
            others = 0;
            for (int b = 1; b < 8; b++) others += hi[b];
            `CHK("full_duty", hi[0], 15)
            `CHK("others_dark", others, 0)
            `CHK("no_extra_sync", extra_sync, 1'b0)
            `CHK("sync_every_15", sync_next, 1'b1)
        end

        // 3a. fade: level steps 15..0, one per 8 cycles, no wrap
        bus_if.pattern_i = 8'h00;
        prev = 15; ndec = 0; bad_step = 0; bad_int = 0; last = 0; zero_at = -1;
        for (int i = 1; i <= 140; i++) begin
            @(negedge clk);
            lvl = int'(dut.level_q[0]);
            if (lvl != prev) begin
                if (lvl != prev - 1) bad_step++;
                if (ndec > 0 && (i - last) != 8) bad_int++;
                ndec++;
                last = i;
                if (lvl == 0) zero_at = i;
            end
            prev = lvl;
        end
        `CHK("fade_decrements", ndec, 15)
        `CHK("fade_step_size", bad_step, 0)
        `CHK("fade_interval", bad_int, 0)
        `CHK("fade_final_zero", dut.level_q[0], 4'd0)
        `CHK("fade_zero_time", (zero_at >= 113 && zero_at <= 120), 1'b1)

        // 3b. fade: duty per period equals shadow latched at its start
        bus_if.pattern_i = 8'h01;
        wait_sync();
        meas();
        meas();
        `CHK("refill_full", hi[0], 15)
        bus_if.pattern_i = 8'h00;
        prev_hi = 16;
        for (int p = 0; p < 10; p++) begin
            meas();
            `CHK("duty_eq_shadow", hi[0], sh0)
            `CHK("duty_monotonic", (hi[0] <= prev_hi), 1'b1)
            if (p == 0) `CHK("fade_first_full", hi[0], 15)
            prev_hi = hi[0];
        end
        `CHK("fade_dark_end", hi[0], 0)

        // 4. load priority over coincident decay tick
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (dut.decay_cnt_q == 3'd7) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        `CHK("tick_align", found, 1'b1)
        bus_if.pattern_i = 8'h08;
        @(negedge clk);
        bus_if.pattern_i = 8'h00;
        `CHK("prio_level", dut.level_q[3], 4'd15)
        repeat (7) @(negedge clk);
        `CHK("pulse_hold", dut.level_q[3], 4'd15)
        @(negedge clk);
        `CHK("pulse_fade", dut.level_q[3], 4'd14)

        // 5. enable toggle
        bus_if.pattern_i = 8'h04;
        wait_sync();
        meas();
        meas();
        `CHK("led2_full", hi[2], 15)
        repeat (5) @(negedge clk);
        `CHK("led2_mid_on", bus_if.led_o[2], 1'b1)
        bus_if.enable_i = 1'b0;
        @(negedge clk);
        `CHK("disable_led", bus_if.led_o, 8'h00)
        `CHK("disable_sync", bus_if.pwm_sync_o, 1'b0)
        repeat (3) @(negedge clk);
        `CHK("disable_level", dut.level_q, 32'd0)
        `CHK("disable_shadow", dut.shadow_q, 32'd0)
        bus_if.enable_i = 1'b1;
        @(negedge clk);
        `CHK("reen_sync", bus_if.pwm_sync_o, 1'b1)
        meas();
        others = 0;
        for (int b = 0; b < 8; b++) others += hi[b];
        `CHK("reen_dark", others, 0)
        `CHK("reen_sync_next", sync_next, 1'b1)
        meas();
        `CHK("reen_full", hi[2], 15)

        // 6. async reset mid-fade
        bus_if.pattern_i = 8'h00;
        meas();
        meas();
        repeat (2) @(negedge clk);
        `CHK("pre_rst_led2", bus_if.led_o[2], 1'b1)
        #1 rstn = 1'b0;
        #1;
        `CHK("async_led", bus_if.led_o, 8'h00)
        `CHK("async_sync", bus_if.pwm_sync_o, 1'b0)
        `CHK("async_level", dut.level_q, 32'd0)
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        `CHK("restart_sync", bus_if.pwm_sync_o, 1'b1)
        `CHK("restart_level", dut.level_q, 32'd0)

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
